// File: rtl/present_decrypt_core_if.sv
// present_decrypt_core_if: start/key/ciphertext request and plaintext/valid/busy response bundle.
interface present_decrypt_core_if;
    logic        start_i;
    logic [79:0] key_i;
    logic [63:0] data_i;
    logic [63:0] data_o;
    logic        valid_o;
    logic        busy_o;
    modport master (output start_i, key_i, data_i, input data_o, valid_o, busy_o);
    modport slave  (input start_i, key_i, data_i, output data_o, valid_o, busy_o);
endinterface

// File: rtl/present_decrypt_core.sv
// present_decrypt_core: iterative PRESENT-80 decryption, one round per cycle.
// Define PRESENT_KEYCACHE_EN to cache K32 of the last key and skip KEYGEN on a repeat key.
module present_decrypt_core (
    input logic clk_i,
    input logic rstn_i,
    present_decrypt_core_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, KEYGEN = 3'd1, WHITEN = 3'd2, ROUND = 3'd3, DONE = 3'd4;
    localparam logic [63:0] SBOX  = 64'h21748FE3DA09B65C;
    localparam logic [63:0] ISBOX = 64'hA970364BD21C8FE5;

    function automatic logic [79:0] fwd_key(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = SBOX[{r[79:76], 2'b00} +: 4];
        r[19:15] = r[19:15] ^ i;
        return r;
    endfunction

    function automatic logic [79:0] rev_key(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r = k;
        r[19:15] = r[19:15] ^ i;
        r[79:76] = ISBOX[{r[79:76], 2'b00} +: 4];
        return {r[60:0], r[79:61]};
    endfunction

    function automatic logic [63:0] inv_round(input logic [63:0] s);
        logic [63:0] p;
        logic [63:0] o;
        for (int j = 0; j < 63; j++) p[j] = s[(16 * j) % 63];
        p[63] = s[63];
        for (int k = 0; k < 16; k++) o[4*k +: 4] = ISBOX[{p[4*k +: 4], 2'b00} +: 4];
        return o;
    endfunction

    logic [2:0]  fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  rnd_q, rnd_d;
    logic        valid_q, valid_d;
    logic        accept, hit;
    logic [79:0] hit_key;

    assign accept = (fsm_q == IDLE || fsm_q == DONE) && bus.start_i;

`ifdef PRESENT_KEYCACHE_EN
    logic [79:0] cached_key_q, cached_k32_q;
    logic        cache_vld_q;
    assign hit     = cache_vld_q && bus.key_i == cached_key_q;
    assign hit_key = cached_k32_q;
    // Key is remembered at start; its K32 becomes usable only once KEYGEN completes.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cached_key_q <= '0;
            cached_k32_q <= '0;
            cache_vld_q  <= 1'b0;
        end else if (accept && !hit) begin
            cached_key_q <= bus.key_i;
            cache_vld_q  <= 1'b0;
        end else if (fsm_q == KEYGEN && rnd_q == 5'd31) begin
            cached_k32_q <= key_d;
            cache_vld_q  <= 1'b1;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_key = '0;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        valid_d = 1'b0;
        case (fsm_q)
            IDLE, DONE: if (accept) begin
                state_d = bus.data_i;
                key_d   = hit ? hit_key : bus.key_i;
                rnd_d   = 5'd1;
                fsm_d   = hit ? WHITEN : KEYGEN;
            end
            KEYGEN: begin
                key_d = fwd_key(key_q, rnd_q);
                rnd_d = rnd_q == 5'd31 ? rnd_q : rnd_q + 5'd1;
                fsm_d = rnd_q == 5'd31 ? WHITEN : KEYGEN;
            end
            WHITEN: begin
                state_d = state_q ^ key_q[79:16];
                key_d   = rev_key(key_q, 5'd31);
                rnd_d   = 5'd31;
                fsm_d   = ROUND;
            end
            ROUND: begin
                state_d = inv_round(state_q) ^ key_q[79:16];
                key_d   = rnd_q == 5'd1 ? key_q : rev_key(key_q, rnd_q - 5'd1);
                rnd_d   = rnd_q == 5'd1 ? rnd_q : rnd_q - 5'd1;
                fsm_d   = rnd_q == 5'd1 ? DONE : ROUND;
                valid_d = rnd_q == 5'd1;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data_o  = fsm_q == DONE ? state_q : '0;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = fsm_q == KEYGEN || fsm_q == WHITEN || fsm_q == ROUND;
endmodule

// File: tb/tb_present_decrypt_core.sv
// tb_present_decrypt_core: directed PRESENT-80 decryption vectors with latency and handshake checks.
module tb_present_decrypt_core;
`ifdef PRESENT_KEYCACHE_EN
    localparam int HIT_LAT = 32;
`else
    localparam int HIT_LAT = 63;
`endif
    localparam logic [79:0] K0 = '0;
    localparam logic [79:0] K1 = '1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    present_decrypt_core_if bus ();
    present_decrypt_core dut (.clk_i(clk), .rstn_i(rstn), .bus(bus.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the start edge E0.
    task automatic launch(input logic [79:0] k, input logic [63:0] d);
        bus.key_i = k;
        bus.data_i = d;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
    endtask

    // Returns edges from E0 to the first valid_o cycle; optionally pulses start while busy.
    task automatic wait_valid(input string tag, input int poke, output int n);
        int busy_cnt;
        int leak;
        n = 0;
        busy_cnt = 0;
        leak = 0;
        forever begin
            @(negedge clk);
            if (bus.valid_o || n >= 200) break;
            if (bus.busy_o) busy_cnt++;
            if (bus.data_o != '0) leak++;
            bus.start_i = (n == poke);
            if (n == poke) bus.data_i = 64'hDEADBEEF01234567;
            n++;
        end
        bus.start_i = 1'b0;
        if (bus.busy_o) leak++;
        check({tag, "_timeout"}, 64'(n >= 200), 64'd0);
        check({tag, "_busy"}, 64'(busy_cnt), 64'(n));
        check({tag, "_leak"}, 64'(leak), 64'd0);
    endtask

    task automatic run(input string tag, input logic [79:0] k, input logic [63:0] d,
                       input logic [63:0] exp, input int lat);
        int n;
        launch(k, d);
        wait_valid(tag, -1, n);
        check({tag, "_data"}, bus.data_o, exp);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.valid_o), 64'd0);
        check({tag, "_hold"}, bus.data_o, exp);
    endtask

    initial begin
        int n1, n2;
        bus.start_i = 1'b0;
        bus.key_i = '0;
        bus.data_i = '0;
        repeat (3) @(negedge clk);
        check("rst_data", bus.data_o, 64'd0);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        run("zero", K0, 64'h5579C1387B228445, 64'h0000000000000000, 63);

        launch(K1, 64'hE72C46C0F5945049);
        repeat (40) @(negedge clk);
        check("mid_busy", 64'(bus.busy_o), 64'd1);
        rstn = 1'b0;
        #1;
        check("abort_data", bus.data_o, 64'd0);
        check("abort_valid", 64'(bus.valid_o), 64'd0);
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run("ones", K1, 64'hE72C46C0F5945049, 64'h0000000000000000, 63);

        launch(K0, 64'hA112FFC72F68417B);
        wait_valid("b2b1", 20, n1);
        check("b2b1_data", bus.data_o, 64'hFFFFFFFFFFFFFFFF);
        check("b2b1_lat", 64'(n1), 64'd63);
        launch(K1, 64'h3333DCD3213210D2);
        wait_valid("b2b2", 10, n2);
        check("b2b2_data", bus.data_o, 64'hFFFFFFFFFFFFFFFF);
        check("b2b_gap", 64'(n2 + 1), 64'd64);
        @(negedge clk);

        run("flush", K0, 64'h5579C1387B228445, 64'h0000000000000000, 63);
        run("cache1", K1, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 63);
        run("cache2", K1, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, HIT_LAT);
        run("cache3", K1, 64'hE72C46C0F5945049, 64'h0000000000000000, HIT_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
